// File: rtl/uart_pkg.sv
// Shared UART receive-path types: one buffered entry is a byte plus its
// parity and framing error flags.
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef struct packed {
      logic                   ferr;
      logic                   perr;
      logic [UART_DATA_W-1:0] data;
   } rx_entry_t;

   localparam int RX_ENTRY_W = $bits(rx_entry_t);

endpackage

// File: rtl/uart_sat_cnt.sv
// Saturating event counter; a clear coinciding with an event leaves the
// count at 1 so that event is not lost.
module uart_sat_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] r_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (clr) begin
         r_q <= inc ? W'(1) : '0;
      end else if (inc && (r_q != '1)) begin
         r_q <= r_q + W'(1);
      end
   end

   assign q = r_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO between the UART receiver and the host, with fill
// level, almost-full, sticky overrun and saturating error statistics.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = 12,
   parameter int CNT_W     = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [UART_DATA_W-1:0]   rx_data,
   input  logic                     rx_valid,
   output logic                     rx_ready,
   input  logic                     rx_parity_err,
   input  logic                     rx_framing_err,
   input  logic                     rx_overrun,
   output logic [UART_DATA_W-1:0]   rd_data,
   output logic                     rd_perr,
   output logic                     rd_ferr,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     almost_full,
   output logic                     overrun_sticky,
   input  logic                     clr_stats,
   output logic [CNT_W-1:0]         perr_cnt,
   output logic [CNT_W-1:0]         ferr_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   rx_entry_t       r_mem [DEPTH];
   logic [AW-1:0]   r_wrPtr;
   logic [AW-1:0]   r_rdPtr;
   logic [LW-1:0]   r_level;
   logic            r_overrunSticky;

   logic            w_notFull;
   logic            w_notEmpty;
   logic            w_push;
   logic            w_pop;
   rx_entry_t       w_wrEntry;
   rx_entry_t       w_head;

   // Handshakes depend only on the registered level, never on rd_ready.
   assign w_notFull  = (r_level != LW'(DEPTH));
   assign w_notEmpty = (r_level != '0);
   assign w_push     = rx_valid && w_notFull;
   assign w_pop      = rd_ready && w_notEmpty;

   assign w_wrEntry.ferr = rx_framing_err;
   assign w_wrEntry.perr = rx_parity_err;
   assign w_wrEntry.data = rx_data;

   always_ff @(posedge clk) begin
      if (rst_n && w_push) begin
         r_mem[r_wrPtr] <= w_wrEntry;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
         if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
         if (w_push && !w_pop)      r_level <= r_level + LW'(1);
         else if (w_pop && !w_push) r_level <= r_level - LW'(1);
      end
   end

   // A set in the same cycle as a clear keeps the flag raised.
   always_ff @(posedge clk) begin
      if (!rst_n)          r_overrunSticky <= 1'b0;
      else if (rx_overrun) r_overrunSticky <= 1'b1;
      else if (clr_stats)  r_overrunSticky <= 1'b0;
   end

   uart_sat_cnt #(.W(CNT_W)) u_perrCnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_stats),
      .inc   (w_push && rx_parity_err),
      .q     (perr_cnt)
   );

   uart_sat_cnt #(.W(CNT_W)) u_ferrCnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_stats),
      .inc   (w_push && rx_framing_err),
      .q     (ferr_cnt)
   );

   assign w_head         = r_mem[r_rdPtr];
   assign rd_data        = w_head.data;
   assign rd_perr        = w_head.perr;
   assign rd_ferr        = w_head.ferr;
   assign rd_valid       = w_notEmpty;
   assign rx_ready       = w_notFull;
   assign level          = r_level;
   assign almost_full    = (r_level >= LW'(AF_THRESH));
   assign overrun_sticky = r_overrunSticky;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo at DEPTH=16, AF_THRESH=12,
// CNT_W=8; inputs change 1 time unit after each rising edge.
module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       rx_parity_err;
   logic       rx_framing_err;
   logic       rx_overrun;
   logic [7:0] rd_data;
   logic       rd_perr;
   logic       rd_ferr;
   logic       rd_valid;
   logic       rd_ready;
   logic [4:0] level;
   logic       almost_full;
   logic       overrun_sticky;
   logic       clr_stats;
   logic [7:0] perr_cnt;
   logic [7:0] ferr_cnt;

   int checkCount = 0;
   int failCount  = 0;

   always #5 clk = ~clk;

   uart_rx_fifo #(.DEPTH(16), .AF_THRESH(12), .CNT_W(8)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_ready       (rx_ready),
      .rx_parity_err  (rx_parity_err),
      .rx_framing_err (rx_framing_err),
      .rx_overrun     (rx_overrun),
      .rd_data        (rd_data),
      .rd_perr        (rd_perr),
      .rd_ferr        (rd_ferr),
      .rd_valid       (rd_valid),
      .rd_ready       (rd_ready),
      .level          (level),
      .almost_full    (almost_full),
      .overrun_sticky (overrun_sticky),
      .clr_stats      (clr_stats),
      .perr_cnt       (perr_cnt),
      .ferr_cnt       (ferr_cnt)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] data, input logic valid,
                                input logic perr, input logic ferr,
                                input logic rdRdy);
      rx_data        = data;
      rx_valid       = valid;
      rx_parity_err  = perr;
      rx_framing_err = ferr;
      rd_ready       = rdRdy;
   endtask

   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n      = 1'b0;
      rx_overrun = 1'b0;
      clr_stats  = 1'b0;
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      stepClock();
      stepClock();
      checkOutput("rst_level", 32'(level), 32'd0);
      checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("rst_rx_ready", 32'(rx_ready), 32'd1);
      checkOutput("rst_almost_full", 32'(almost_full), 32'd0);
      checkOutput("rst_overrun", 32'(overrun_sticky), 32'd0);
      checkOutput("rst_perr_cnt", 32'(perr_cnt), 32'd0);
      checkOutput("rst_ferr_cnt", 32'(ferr_cnt), 32'd0);
      rst_n = 1'b1;

      // Single byte through, then popped.
      applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
      stepClock();
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("single_rd_valid", 32'(rd_valid), 32'd1);
      checkOutput("single_rd_data", 32'(rd_data), 32'hA5);
      checkOutput("single_level", 32'(level), 32'd1);
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      stepClock();
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("single_pop_level", 32'(level), 32'd0);
      checkOutput("single_pop_rd_valid", 32'(rd_valid), 32'd0);

      // Fill to DEPTH, then offer a held 17th byte.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
         stepClock();
         if (i == 10) checkOutput("fill_af_at_11", 32'(almost_full), 32'd0);
         if (i == 11) checkOutput("fill_af_at_12", 32'(almost_full), 32'd1);
         if (i == 14) checkOutput("fill_ready_at_15", 32'(rx_ready), 32'd1);
      end
      checkOutput("full_level", 32'(level), 32'd16);
      checkOutput("full_rx_ready", 32'(rx_ready), 32'd0);
      applyStimulus(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
      stepClock();
      checkOutput("full_hold_level", 32'(level), 32'd16);
      checkOutput("full_hold_rx_ready", 32'(rx_ready), 32'd0);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(8'h55, (i < 2) ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b1);
         checkOutput("drain_data", 32'(rd_data), 32'(i));
         stepClock();
         if (i == 0) begin
            checkOutput("pop_full_level", 32'(level), 32'd15);
            checkOutput("pop_full_rx_ready", 32'(rx_ready), 32'd1);
         end
         if (i == 1) checkOutput("push_pop_level", 32'(level), 32'd15);
      end
      checkOutput("drain_held_data", 32'(rd_data), 32'h55);
      checkOutput("drain_held_level", 32'(level), 32'd1);
      stepClock();
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("drain_empty_level", 32'(level), 32'd0);
      checkOutput("drain_empty_valid", 32'(rd_valid), 32'd0);

      // Steady push+pop at level 5 across pointer wrap.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(8'(8'h80 + i), 1'b1, 1'b0, 1'b0, 1'b0);
         stepClock();
      end
      checkOutput("stream_start_level", 32'(level), 32'd5);
      for (int k = 0; k < 40; k++) begin
         applyStimulus(8'(8'h85 + k), 1'b1, 1'b0, 1'b0, 1'b1);
         checkOutput("stream_data", 32'(rd_data), 32'(8'h80 + k));
         stepClock();
         checkOutput("stream_level", 32'(level), 32'd5);
      end
      for (int j = 0; j < 5; j++) begin
         applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
         checkOutput("stream_tail_data", 32'(rd_data), 32'(8'hA8 + j));
         stepClock();
      end
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("stream_end_level", 32'(level), 32'd0);

      // Per-entry error flags and counters.
      applyStimulus(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
      stepClock();
      applyStimulus(8'h7E, 1'b1, 1'b0, 1'b1, 1'b0);
      stepClock();
      applyStimulus(8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
      stepClock();
      checkOutput("err_perr_cnt", 32'(perr_cnt), 32'd1);
      checkOutput("err_ferr_cnt", 32'(ferr_cnt), 32'd1);
      checkOutput("err_head0_data", 32'(rd_data), 32'h3C);
      checkOutput("err_head0_flags", 32'({rd_perr, rd_ferr}), 32'b10);
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      stepClock();
      checkOutput("err_head1_data", 32'(rd_data), 32'h7E);
      checkOutput("err_head1_flags", 32'({rd_perr, rd_ferr}), 32'b01);
      stepClock();
      checkOutput("err_empty_level", 32'(level), 32'd0);

      // Saturation, then clear coinciding with an error push.
      for (int k = 0; k < 300; k++) begin
         applyStimulus(8'(k), 1'b1, 1'b1, 1'b0, 1'b1);
         stepClock();
         if (k == 252) checkOutput("sat_254", 32'(perr_cnt), 32'd254);
         if (k == 253) checkOutput("sat_255", 32'(perr_cnt), 32'd255);
      end
      checkOutput("sat_hold", 32'(perr_cnt), 32'd255);
      checkOutput("sat_level", 32'(level), 32'd1);
      applyStimulus(8'hEE, 1'b1, 1'b1, 1'b0, 1'b1);
      clr_stats = 1'b1;
      stepClock();
      clr_stats = 1'b0;
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("clr_inc_perr", 32'(perr_cnt), 32'd1);
      checkOutput("clr_ferr", 32'(ferr_cnt), 32'd0);
      stepClock();
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("sat_drain_level", 32'(level), 32'd0);

      // Sticky overrun: set wins over a simultaneous clear.
      rx_overrun = 1'b1;
      stepClock();
      rx_overrun = 1'b0;
      checkOutput("ovr_set", 32'(overrun_sticky), 32'd1);
      rx_overrun = 1'b1;
      clr_stats  = 1'b1;
      stepClock();
      rx_overrun = 1'b0;
      checkOutput("ovr_set_and_clr", 32'(overrun_sticky), 32'd1);
      checkOutput("ovr_clr_perr", 32'(perr_cnt), 32'd0);
      stepClock();
      clr_stats = 1'b0;
      checkOutput("ovr_cleared", 32'(overrun_sticky), 32'd0);

      // Reset mid-operation at level 7.
      for (int i = 0; i < 7; i++) begin
         applyStimulus(8'(8'h10 + i), 1'b1, (i < 2) ? 1'b1 : 1'b0,
                       (i < 3) ? 1'b1 : 1'b0, 1'b0);
         stepClock();
      end
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("pre_rst_level", 32'(level), 32'd7);
      checkOutput("pre_rst_perr", 32'(perr_cnt), 32'd2);
      checkOutput("pre_rst_ferr", 32'(ferr_cnt), 32'd3);
      rst_n = 1'b0;
      stepClock();
      rst_n = 1'b1;
      checkOutput("mid_rst_level", 32'(level), 32'd0);
      checkOutput("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("mid_rst_rx_ready", 32'(rx_ready), 32'd1);
      checkOutput("mid_rst_perr", 32'(perr_cnt), 32'd0);
      checkOutput("mid_rst_ferr", 32'(ferr_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
